// File: rtl/video_vga_timing_pkg.sv
// Shared definitions for the VGA timing generator: default 640x480@60 timing,
// sync polarity constants and the run/stop state encoding.
package video_pkg;

  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK_PORCH  = 33;

  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vga_state_e;

endpackage

// File: rtl/video_vga_timing_delay_line.sv
// Parametrised width/depth shift register with async reset, used to align
// raster-derived signals with the pixel pipeline.
module video_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_vga_timing.sv
// Programmable VGA timing generator with run/stop FSM, raster strobes and
// pipeline-compensated colour/sync outputs. Optional colour bars: VGA_TEST_PATTERN_EN.
module video_vga_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int H_FRONT_PORCH  = DEF_H_FRONT_PORCH,
  parameter int H_SYNC         = DEF_H_SYNC,
  parameter int H_BACK_PORCH   = DEF_H_BACK_PORCH,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int V_FRONT_PORCH  = DEF_V_FRONT_PORCH,
  parameter int V_SYNC         = DEF_V_SYNC,
  parameter int V_BACK_PORCH   = DEF_V_BACK_PORCH,
  parameter int HSYNC_POL      = SYNC_ACTIVE_LOW,
  parameter int VSYNC_POL      = SYNC_ACTIVE_LOW,
  parameter int COLOR_W        = 4,
  parameter int PIPE_DELAY     = 2,
  parameter int PREFETCH_LINES = 1,
  parameter int CNT_W          = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_pattern,
`endif
  input  logic [CNT_W-1:0]     irq_line,
  input  logic [3*COLOR_W-1:0] pixel_rgb,
  output logic                 running,
  output logic [CNT_W-1:0]     x_pos,
  output logic [CNT_W-1:0]     y_pos,
  output logic                 next_frame,
  output logic                 next_line,
  output logic                 next_pixel,
  output logic                 vblank_pulse,
  output logic                 line_match,
  output logic [7:0]           frame_count,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);
  localparam logic [CNT_W-1:0] Y_PREFETCH = CNT_W'(V_TOTAL - 1 - PREFETCH_LINES);
  localparam logic [CNT_W-1:0] Y_VBLANK   = CNT_W'(V_ACTIVE - 1);
  localparam logic             HS_ON      = (HSYNC_POL != 0);
  localparam logic             VS_ON      = (VSYNC_POL != 0);

  vga_state_e       state;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             h_last;
  logic             v_last;

  assign running = (state == ST_RUN) || (state == ST_STOPPING);
  assign h_last  = running && (x == X_LAST);
  assign v_last  = (y == Y_LAST);

  // STOPPING keeps the raster moving so the current frame completes before idling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          x <= '0;
          y <= '0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN, ST_STOPPING: begin
          x <= h_last ? '0 : x + 1'b1;
          if (h_last) y <= v_last ? '0 : y + 1'b1;
          if (h_last && v_last) frame_count <= frame_count + 8'd1;
          if (enable)
            state <= ST_RUN;
          else if (state == ST_STOPPING && h_last && v_last)
            state <= ST_IDLE;
          else
            state <= ST_STOPPING;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign x_pos        = x;
  assign y_pos        = y;
  assign next_pixel   = running;
  assign next_line    = h_last;
  assign next_frame   = h_last && (y == Y_PREFETCH);
  assign vblank_pulse = h_last && (y == Y_VBLANK);
  assign line_match   = h_last && (y == irq_line);

  logic [2:0] raw_flags;
  logic [2:0] dly_flags;

  assign raw_flags[2] = running && (x < X_ACT) && (y < Y_ACT);
  assign raw_flags[1] = running && (x >= HS_START) && (x < HS_END);
  assign raw_flags[0] = running && (y >= VS_START) && (y < VS_END);

  video_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_flag_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (raw_flags),
    .dout (dly_flags)
  );

  logic [3*COLOR_W-1:0] rgb_src;

`ifdef VGA_TEST_PATTERN_EN
  logic [CNT_W-1:0]     x_dly;
  logic [2:0]           bar;
  logic [3*COLOR_W-1:0] bar_rgb;
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  video_delay_line #(.WIDTH(CNT_W), .DEPTH(PIPE_DELAY)) u_x_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (x),
    .dout (x_dly)
  );

  always_comb begin
    bar = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (x_dly >= CNT_W'(b * BAR_W)) bar = b[2:0];
    end
  end

  assign bar_rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
  assign rgb_src = test_pattern ? bar_rgb : pixel_rgb;
`else
  assign rgb_src = pixel_rgb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hsync             <= ~HS_ON;
      vga_vsync             <= ~VS_ON;
    end else begin
      {vga_r, vga_g, vga_b} <= dly_flags[2] ? rgb_src : '0;
      vga_hsync             <= dly_flags[1] ? HS_ON : ~HS_ON;
      vga_vsync             <= dly_flags[0] ? VS_ON : ~VS_ON;
    end
  end

endmodule
